// File: rtl/tag_cpl_tracker_if.sv
// Handshake bundle between the read-request generator, the CplD header parser,
// the tag allocator's free port and the completion tag tracker.
interface tag_cpl_tracker_if #(
    parameter int PCIE_TAG_BITS = 5,
    parameter int LEN_BITS      = 10
);
    logic [PCIE_TAG_BITS-1:0] s_req_tag;
    logic [LEN_BITS-1:0]      s_req_len;
    logic                     s_req_valid;
    logic                     s_req_ready;

    logic [PCIE_TAG_BITS-1:0] s_cpl_tag;
    logic [LEN_BITS-1:0]      s_cpl_len;
    logic                     s_cpl_valid;
    logic                     s_cpl_ready;

    logic [PCIE_TAG_BITS-1:0] m_tag_free_data;
    logic                     m_tag_free_valid;
    logic                     m_tag_free_ready;

    modport slave (
        input  s_req_tag, s_req_len, s_req_valid,
        output s_req_ready,
        input  s_cpl_tag, s_cpl_len, s_cpl_valid,
        output s_cpl_ready,
        output m_tag_free_data, m_tag_free_valid,
        input  m_tag_free_ready
    );

    modport master (
        output s_req_tag, s_req_len, s_req_valid,
        input  s_req_ready,
        output s_cpl_tag, s_cpl_len, s_cpl_valid,
        input  s_cpl_ready,
        input  m_tag_free_data, m_tag_free_valid,
        output m_tag_free_ready
    );
endinterface

// File: rtl/tag_cpl_tracker.sv
// Tracks outstanding PCIe read tags, counts completion DWs per tag and releases
// each tag on the free port once its requested length has been fully returned.
module tag_cpl_tracker #(
    parameter int PCIE_TAG_BITS = 5,
    parameter int LEN_BITS      = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tag_cpl_tracker_if.slave       bus,
    output logic [PCIE_TAG_BITS:0] outstanding,
    output logic                   err_dup_req,
    output logic                   err_unexp_cpl,
    output logic                   err_overrun
);
    localparam int NT = 1 << PCIE_TAG_BITS;
    localparam int RW = LEN_BITS + 1;

    logic [NT-1:0]            busy_q, busy_d;
    logic [RW-1:0]            rem_q [NT];
    logic [RW-1:0]            rem_d [NT];
    logic                     rdy_q;
    logic                     free_valid_q, free_valid_d;
    logic [PCIE_TAG_BITS-1:0] free_data_q, free_data_d;
    logic [PCIE_TAG_BITS:0]   outstanding_q, outstanding_d;
    logic                     dup_q, dup_d;
    logic                     unexp_q, unexp_d;
    logic                     overrun_q, overrun_d;

    logic                     req_fire, req_accept;
    logic                     cpl_fire, cpl_hit, cpl_done;
    logic [RW-1:0]            req_len_exp, cpl_len_exp, cpl_rem;

    // A zero length field means 2^LEN_BITS DW; prepending the zero flag encodes that.
    assign req_len_exp = {(bus.s_req_len == '0), bus.s_req_len};
    assign cpl_len_exp = {(bus.s_cpl_len == '0), bus.s_cpl_len};

    assign bus.s_req_ready      = rdy_q;
    assign bus.s_cpl_ready      = rdy_q && (!free_valid_q || bus.m_tag_free_ready);
    assign bus.m_tag_free_valid = free_valid_q;
    assign bus.m_tag_free_data  = free_data_q;
    assign outstanding          = outstanding_q;
    assign err_dup_req          = dup_q;
    assign err_unexp_cpl        = unexp_q;
    assign err_overrun          = overrun_q;

    // Request and completion both look only at pre-cycle busy/rem, so a completion
    // freeing a tag cannot make a same-cycle request on that tag legal.
    assign req_fire   = bus.s_req_valid && rdy_q;
    assign req_accept = req_fire && !busy_q[bus.s_req_tag];
    assign cpl_fire   = bus.s_cpl_valid && bus.s_cpl_ready;
    assign cpl_hit    = cpl_fire && busy_q[bus.s_cpl_tag];
    assign cpl_rem    = rem_q[bus.s_cpl_tag];
    assign cpl_done   = cpl_hit && (cpl_len_exp >= cpl_rem);

    always_comb begin
        busy_d        = busy_q;
        rem_d         = rem_q;
        free_valid_d  = free_valid_q;
        free_data_d   = free_data_q;
        dup_d         = req_fire && busy_q[bus.s_req_tag];
        unexp_d       = cpl_fire && !busy_q[bus.s_cpl_tag];
        overrun_d     = cpl_hit && (cpl_len_exp > cpl_rem);
        outstanding_d = outstanding_q
                        + {{PCIE_TAG_BITS{1'b0}}, req_accept}
                        - {{PCIE_TAG_BITS{1'b0}}, cpl_done};

        if (cpl_hit && !cpl_done) begin
            rem_d[bus.s_cpl_tag] = cpl_rem - cpl_len_exp;
        end
        if (cpl_done) begin
            busy_d[bus.s_cpl_tag] = 1'b0;
            free_valid_d          = 1'b1;
            free_data_d           = bus.s_cpl_tag;
        end else if (bus.m_tag_free_ready) begin
            free_valid_d = 1'b0;
        end
        // Accepted request targets an idle tag, so it never collides with a completion write.
        if (req_accept) begin
            busy_d[bus.s_req_tag] = 1'b1;
            rem_d[bus.s_req_tag]  = req_len_exp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= '0;
            rdy_q         <= 1'b0;
            free_valid_q  <= 1'b0;
            free_data_q   <= '0;
            outstanding_q <= '0;
            dup_q         <= 1'b0;
            unexp_q       <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            rdy_q         <= 1'b1;
            free_valid_q  <= free_valid_d;
            free_data_q   <= free_data_d;
            outstanding_q <= outstanding_d;
            dup_q         <= dup_d;
            unexp_q       <= unexp_d;
            overrun_q     <= overrun_d;
        end
    end

    // Remaining-DW table is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk) begin
        rem_q <= rem_d;
    end
endmodule

// File: tb/tb_tag_cpl_tracker.sv
// Self-checking bench for tag_cpl_tracker: directed vector table, hand-written
// corner sequences and randomized traffic against a per-tag reference model.
module tb_tag_cpl_tracker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] outstanding;
    logic       err_dup_req, err_unexp_cpl, err_overrun;

    always #5 clk = ~clk;

    tag_cpl_tracker_if #(.PCIE_TAG_BITS(5), .LEN_BITS(10)) bus ();

    tag_cpl_tracker #(.PCIE_TAG_BITS(5), .LEN_BITS(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .outstanding  (outstanding),
        .err_dup_req  (err_dup_req),
        .err_unexp_cpl(err_unexp_cpl),
        .err_overrun  (err_overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit verbose = 1'b1;

    // Reference model: which tags are busy, how many DW each still expects,
    // the single-entry release slot, and the errors raised by the last cycle.
    bit busy_m [32];
    int rem_m  [32];
    int out_m;
    bit fv_m;
    int fd_m;
    bit dup_m, unexp_m, ovr_m;

    typedef struct {
        bit rv; int rt; int rl;
        bit cv; int ct; int cl;
        bit fr;
        bit efv; int efd; int eout;
        bit edup; bit eunexp; bit eovr;
    } vec_t;

    vec_t vt [16];

    function automatic int expand(input int len);
        return (len == 0) ? 1024 : len;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            busy_m[i] = 1'b0;
            rem_m[i]  = 0;
        end
        out_m = 0; fv_m = 1'b0; fd_m = 0;
        dup_m = 1'b0; unexp_m = 1'b0; ovr_m = 1'b0;
    endtask

    // One clock cycle: drive inputs, check the combinational readies, advance
    // the model with the pre-cycle state, then check the registered outputs.
    task automatic step(input bit rv, input int rt, input int rl,
                        input bit cv, input int ct, input int cl, input bit fr);
        bit exp_crdy, acc, done;
        int L;
        bus.s_req_valid      = rv;
        bus.s_req_tag        = rt[4:0];
        bus.s_req_len        = rl[9:0];
        bus.s_cpl_valid      = cv;
        bus.s_cpl_tag        = ct[4:0];
        bus.s_cpl_len        = cl[9:0];
        bus.m_tag_free_ready = fr;
        #1;
        exp_crdy = !fv_m || fr;
        chk("s_req_ready", int'(bus.s_req_ready), 1);
        chk("s_cpl_ready", int'(bus.s_cpl_ready), int'(exp_crdy));

        dup_m = 1'b0; unexp_m = 1'b0; ovr_m = 1'b0; acc = 1'b0; done = 1'b0;
        if (rv) begin
            if (busy_m[rt]) dup_m = 1'b1;
            else            acc = 1'b1;
        end
        if (cv && exp_crdy) begin
            if (!busy_m[ct]) unexp_m = 1'b1;
            else begin
                L = expand(cl);
                if (L >= rem_m[ct]) begin
                    done  = 1'b1;
                    ovr_m = (L > rem_m[ct]);
                end else begin
                    rem_m[ct] = rem_m[ct] - L;
                end
            end
        end
        if (done) begin
            busy_m[ct] = 1'b0;
            fv_m = 1'b1;
            fd_m = ct;
        end else if (fr) begin
            fv_m = 1'b0;
        end
        if (acc) begin
            busy_m[rt] = 1'b1;
            rem_m[rt]  = expand(rl);
        end
        out_m = out_m + int'(acc) - int'(done);

        @(posedge clk);
        #1;
        chk("outstanding", int'(outstanding), out_m);
        chk("free_valid", int'(bus.m_tag_free_valid), int'(fv_m));
        if (fv_m) chk("free_data", int'(bus.m_tag_free_data), fd_m);
        chk("err_dup_req", int'(err_dup_req), int'(dup_m));
        chk("err_unexp_cpl", int'(err_unexp_cpl), int'(unexp_m));
        chk("err_overrun", int'(err_overrun), int'(ovr_m));
        if (verbose)
            $display("[TB] req v%0d t%0d l%0d | cpl v%0d t%0d l%0d | fr%0d -> out=%0d fv=%0d fd=%0d err=%0d%0d%0d",
                     rv, rt, rl, cv, ct, cl, fr, outstanding, bus.m_tag_free_valid,
                     bus.m_tag_free_data, err_dup_req, err_unexp_cpl, err_overrun);
        bus.s_req_valid = 1'b0;
        bus.s_cpl_valid = 1'b0;
    endtask

    task automatic idle(input bit fr);
        step(1'b0, 0, 0, 1'b0, 0, 0, fr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_req_ready", int'(bus.s_req_ready), 0);
        chk("rst_cpl_ready", int'(bus.s_cpl_ready), 0);
        chk("rst_free_valid", int'(bus.m_tag_free_valid), 0);
        chk("rst_free_data", int'(bus.m_tag_free_data), 0);
        chk("rst_outstanding", int'(outstanding), 0);
        chk("rst_errs", int'({err_dup_req, err_unexp_cpl, err_overrun}), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.s_req_valid = 1'b0; bus.s_req_tag = '0; bus.s_req_len = '0;
        bus.s_cpl_valid = 1'b0; bus.s_cpl_tag = '0; bus.s_cpl_len = '0;
        bus.m_tag_free_ready = 1'b1;

        //            rv  rt  rl  cv  ct  cl  fr  efv efd eout dup unx ovr
        vt[0]  = '{1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 3, 16, 1'b0, 0, 0, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 0, 0, 1'b1, 3, 8, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 0, 0, 1'b1, 3, 8, 1'b1, 1'b1, 3, 0, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 0, 0, 1'b1, 9, 1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 4, 2, 1'b0, 0, 0, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 4, 2, 1'b0, 0, 0, 1'b1, 1'b0, 0, 1, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 5, 4, 1'b0, 0, 0, 1'b1, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 0, 0, 1'b1, 5, 6, 1'b1, 1'b1, 5, 1, 1'b0, 1'b0, 1'b1};
        vt[10] = '{1'b0, 0, 0, 1'b1, 4, 2, 1'b1, 1'b1, 4, 0, 1'b0, 1'b0, 1'b0};
        vt[11] = '{1'b1, 6, 3, 1'b0, 0, 0, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b1, 6, 5, 1'b1, 6, 3, 1'b1, 1'b1, 6, 0, 1'b1, 1'b0, 1'b0};
        vt[13] = '{1'b1, 8, 2, 1'b1, 8, 1, 1'b1, 1'b0, 0, 1, 1'b0, 1'b1, 1'b0};
        vt[14] = '{1'b0, 0, 0, 1'b1, 8, 2, 1'b1, 1'b1, 8, 0, 1'b0, 1'b0, 1'b0};
        vt[15] = '{1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};

        do_reset();

        for (int i = 0; i < 16; i++) begin
            step(vt[i].rv, vt[i].rt, vt[i].rl, vt[i].cv, vt[i].ct, vt[i].cl, vt[i].fr);
            chk("vec_free_valid", int'(bus.m_tag_free_valid), int'(vt[i].efv));
            if (vt[i].efv) chk("vec_free_data", int'(bus.m_tag_free_data), vt[i].efd);
            chk("vec_outstanding", int'(outstanding), vt[i].eout);
            chk("vec_errs", int'({err_dup_req, err_unexp_cpl, err_overrun}),
                int'({vt[i].edup, vt[i].eunexp, vt[i].eovr}));
        end

        // 1024-DW request split into eight 128-DW completions.
        step(1'b1, 7, 0, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 0, 0, 1'b1, 7, 128, 1'b1);
            chk("len1024_release", int'(bus.m_tag_free_valid), (i == 7) ? 1 : 0);
        end
        idle(1'b1);

        // Stalled free port back-pressures completions and holds the release.
        step(1'b1, 1, 1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 2, 1, 1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b1, 1, 1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 0, 0, 1'b1, 2, 1, 1'b0);
            chk("stall_data", int'(bus.m_tag_free_data), 1);
        end
        step(1'b0, 0, 0, 1'b1, 2, 1, 1'b1);
        chk("unstall_data", int'(bus.m_tag_free_data), 2);
        idle(1'b1);

        // Fill the whole table, then drain it at one release per cycle.
        for (int t = 0; t < 32; t++) step(1'b1, t, 1, 1'b0, 0, 0, 1'b1);
        chk("full_outstanding", int'(outstanding), 32);
        step(1'b1, 0, 1, 1'b0, 0, 0, 1'b1);
        for (int t = 0; t < 32; t++) begin
            step(1'b0, 0, 0, 1'b1, t, 1, 1'b1);
            chk("drain_data", int'(bus.m_tag_free_data), t);
        end
        idle(1'b1);
        chk("drained_outstanding", int'(outstanding), 0);

        // Randomized traffic on a few tags to force collisions and overruns.
        verbose = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            step($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), r,
                 $urandom_range(0, 4) < 3, int'($urandom_range(0, 7)),
                 int'($urandom_range(1, 6)), $urandom_range(0, 3) != 0);
        end
        verbose = 1'b1;

        // Reset in the middle of traffic drops all state.
        step(1'b1, 10, 5, 1'b0, 0, 0, 1'b1);
        do_reset();
        idle(1'b1);
        step(1'b1, 10, 1, 1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1, 10, 1, 1'b1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tag_cpl_tracker.md
Name: tag_cpl_tracker

Overview:
- Return path for PCIe read tags: tracks each issued non-posted read by tag and counts the completion data received against it.
- When the last completion DW for a tag arrives, the tag is released on an AXI-stream style free port.
- The free port connects directly to the tag-free input of the tag allocator.
- Sits between the read-request generator and the completion (CplD) header parser in the PCIe DMA read engine.

Parameters:
- PCIE_TAG_BITS, 5, tag width; 2^PCIE_TAG_BITS tracked tags.
- LEN_BITS, 10, TLP length field width in DW; encoding 0 means 2^LEN_BITS DW.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_req_tag  in  PCIE_TAG_BITS  tag of the issued read request.
- s_req_len  in  LEN_BITS  requested length in DW (0 = 1024).
- s_req_valid  in  1  request issued.
- s_req_ready  out  1  tracker accepts a request.
- s_cpl_tag  in  PCIE_TAG_BITS  tag from the completion header.
- s_cpl_len  in  LEN_BITS  payload length of this completion in DW (0 = 1024).
- s_cpl_valid  in  1  completion header valid.
- s_cpl_ready  out  1  tracker accepts the completion.
- m_tag_free_data  out  PCIE_TAG_BITS  tag being released.
- m_tag_free_valid  out  1  release valid.
- m_tag_free_ready  in  1  downstream accepts the release.
- outstanding  out  PCIE_TAG_BITS+1  number of busy tags (0..2^PCIE_TAG_BITS).
- err_dup_req  out  1  one-cycle pulse: request was issued to a tag that is already busy.
- err_unexp_cpl  out  1  one-cycle pulse: completion arrived for an idle tag.
- err_overrun  out  1  one-cycle pulse: completion length exceeds the remaining DW for its tag.

Behaviour:
- State per tag: busy bit, plus rem counter of LEN_BITS+1 bits holding remaining DW. Each length field is expanded before use: 0 -> 2^LEN_BITS.
- Reset (rst_n low, async): all busy bits cleared; outstanding=0; m_tag_free_valid=0; m_tag_free_data=0; all err outputs=0; s_req_ready=0; s_cpl_ready=0. Deassertion is used synchronously. rem contents are don't-care.
- s_req_ready=1 whenever out of reset. A request always completes its handshake.
- Request handshake on idle tag:
  - busy[tag] is set and rem[tag] is loaded with the expanded length.
  - Both take effect from the next cycle.
- Request handshake on busy tag: ignored, and err_dup_req pulses next cycle.
- s_cpl_ready = !m_tag_free_valid || m_tag_free_ready. The output register is a single entry; stalling the free port back-pressures completions.
- Completion handshake on busy tag with expanded length L < rem: rem[tag] -= L. Tag stays busy.
- Completion handshake with L == rem:
  - busy[tag] cleared.
  - m_tag_free_valid=1 and m_tag_free_data=tag on the next cycle (latency 1).
- Completion handshake with L > rem:
  - err_overrun pulses.
  - The tag is released exactly as in the L == rem case, so the tag is never leaked.
- Completion handshake on idle tag: dropped, no release, and err_unexp_cpl pulses.
- m_tag_free_valid stays high with data stable until m_tag_free_ready. It clears on accept unless a new release is loaded in the same cycle (back-to-back throughput of 1 per cycle).
- Simultaneous request and completion in one cycle:
  - Both are evaluated against the pre-cycle state.
  - Same tag while the tag is busy: the completion is processed normally, and the request is flagged err_dup_req and ignored (even if the completion frees the tag).
  - Same tag while the tag is idle: the request is accepted, the completion is flagged err_unexp_cpl, and the tag becomes busy with the full length.
- outstanding counter:
  - +1 on each accepted request, -1 on each release.
  - Both in one cycle: unchanged.
  - Never wraps, since a full table cannot accept a new request without err_dup_req.
- Reset mid-operation: all state is lost. The allocator is reset in the same domain and refills its FIFO, so no releases are owed.

Test Plan:
- Reset then idle -> s_req_ready=1, s_cpl_ready=1, outstanding=0, no valid, no err pulses.
- Req tag 3 len 16; cpl tag 3 len 8, then cpl tag 3 len 8 -> no release after the first; release tag 3 one cycle after the second; outstanding 1->0.
- Req tag 7 len 0; 8 completions of len 128 -> release tag 7 only after the 8th (1024 DW total).
- Hold m_tag_free_ready=0; single-cycle cpl releases tag 1; second cpl for tag 2 offered -> s_cpl_ready=0, data stays 1. Raise ready -> tag 1 accepted, then tag 2 released next cycle.
- Req all 32 tags len 1, then 32 back-to-back cpls with ready=1 -> outstanding reaches 32; 32 releases at 1 per cycle; outstanding returns to 0.
- Error cases:
  - cpl tag 9 while idle -> err_unexp_cpl pulse, no release.
  - Req tag 4 twice -> err_dup_req pulse.
  - Req tag 5 len 4 then cpl len 6 -> err_overrun pulse and tag 5 released.
